// File: rtl/pmodr2r_sample_pacer.sv
// Paced DAC-code source: AXI-Stream in, FIFO, one code per sample period onto a GPIO tri bundle.
// Optional macro PMODR2R_PACER_TLAST_EN stores tlast with each code and pulses frame_done on pop.
module pmodr2r_sample_pacer #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  IDLE_CODE  = 8'h80
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [7:0]                  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  input  logic                        enable,
  input  logic [DIV_WIDTH-1:0]        div,
  input  logic                        clear_underrun,
  output logic [7:0]                  gpio_out_tri_o,
  output logic [7:0]                  gpio_out_tri_t,
  input  logic [7:0]                  gpio_out_tri_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun,
  output logic                        frame_done
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
`ifdef PMODR2R_PACER_TLAST_EN
  localparam int unsigned EW = 9;
`else
  localparam int unsigned EW = 8;
`endif

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [DIV_WIDTH-1:0] cnt;

  logic          tick_c;
  logic          empty_c;
  logic          full_c;
  logic          push_c;
  logic          pop_c;
  logic [PW-1:0] level_nxt_c;
  logic [EW-1:0] wr_entry_c;
  logic [EW-1:0] rd_entry_c;

  // Readback from the remap stage is not needed; tlast is only consumed with the macro.
  logic unused_inputs;
  assign unused_inputs = ^{gpio_out_tri_i, s_axis_tlast};

  assign gpio_out_tri_t = 8'h00;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // >= so that lowering div below the running count ticks at once instead of wrapping.
  assign tick_c  = enable && (cnt >= div);
  assign push_c  = s_axis_tvalid && s_axis_tready && !full_c;
  assign pop_c   = tick_c && !empty_c;

  always_comb begin
    level_nxt_c = fifo_level;
    if (push_c && !pop_c) begin
      level_nxt_c = fifo_level + PW'(1);
    end else if (pop_c && !push_c) begin
      level_nxt_c = fifo_level - PW'(1);
    end
  end

`ifdef PMODR2R_PACER_TLAST_EN
  assign wr_entry_c = {s_axis_tlast, s_axis_tdata};
`else
  assign wr_entry_c = s_axis_tdata;
`endif
  assign rd_entry_c = mem[rd_ptr[AW-1:0]];

  // Storage array, no reset needed: entries are only read behind the write pointer.
  always_ff @(posedge aclk) begin
    if (push_c) begin
      mem[wr_ptr[AW-1:0]] <= wr_entry_c;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      s_axis_tready  <= 1'b0;
      cnt            <= '0;
      gpio_out_tri_o <= IDLE_CODE;
      underrun       <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_level    <= level_nxt_c;
      s_axis_tready <= (level_nxt_c != PW'(FIFO_DEPTH));
      cnt           <= (!enable || tick_c) ? '0 : cnt + DIV_WIDTH'(1);
      if (!enable) begin
        gpio_out_tri_o <= IDLE_CODE;
      end else if (pop_c) begin
        gpio_out_tri_o <= rd_entry_c[7:0];
      end
      // A new underrun in the same cycle as a clear keeps the flag set.
      underrun <= (tick_c && empty_c) || (underrun && !clear_underrun);
`ifdef PMODR2R_PACER_TLAST_EN
      frame_done <= pop_c && rd_entry_c[8];
`else
      frame_done <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pmodr2r_sample_pacer.sv
// Bench for pmodr2r_sample_pacer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pmodr2r_sample_pacer;
  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        enable;
  logic [15:0] div;
  logic        clear_underrun;
  logic [7:0]  tri_o;
  logic [7:0]  tri_t;
  logic [7:0]  tri_i;
  logic [4:0]  fifo_level;
  logic        underrun;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  pmodr2r_sample_pacer dut (
    .aclk(clk), .aresetn(aresetn),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tlast(tlast),
    .enable(enable), .div(div), .clear_underrun(clear_underrun),
    .gpio_out_tri_o(tri_o), .gpio_out_tri_t(tri_t), .gpio_out_tri_i(tri_i),
    .fifo_level(fifo_level), .underrun(underrun), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending codes and a count of cycles into the current period.
  logic [8:0] q[$];
  int         m_phase;
  logic [7:0] m_tri;
  logic       m_under, m_fd, m_ready;
  logic       m_valid = 1'b0;

  always @(posedge clk) begin : model_b
    logic       tk;
    int         sz;
    logic [8:0] e;
    logic [7:0] nt;
    logic       nfd;
    if (!aresetn) begin
      q.delete();
      m_phase <= 0;
      m_tri   <= 8'h80;
      m_under <= 1'b0;
      m_fd    <= 1'b0;
      m_ready <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      sz  = q.size();
      tk  = enable && (m_phase >= int'(div));
      nt  = m_tri;
      nfd = 1'b0;
      if (tk && sz > 0) begin
        e  = q.pop_front();
        nt = e[7:0];
`ifdef PMODR2R_PACER_TLAST_EN
        nfd = e[8];
`endif
      end
      if (!enable) nt = 8'h80;
      m_tri   <= nt;
      m_fd    <= nfd;
      m_under <= (tk && sz == 0) || (m_under && !clear_underrun);
      if (tvalid && m_ready) q.push_back({tlast, tdata});
      m_phase <= (enable && !tk) ? m_phase + 1 : 0;
      m_ready <= (q.size() != 16);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tri_o", 32'(tri_o), 32'(m_tri));
      chk("tri_t", 32'(tri_t), 32'h0);
      chk("level", 32'(fifo_level), 32'(q.size()));
      chk("underrun", 32'(underrun), 32'(m_under));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
      chk("tready", 32'(tready), 32'(m_ready));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step(2);
    aresetn = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    tdata = d; tlast = l; tvalid = 1'b1;
    step(1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg_at[3];
    int nchg;
    logic [7:0] prev;
    bit found;
    int pulses;
    logic [7:0] pulse_tri;

    aresetn = 1'b0; tdata = 8'h00; tvalid = 1'b0; tlast = 1'b0;
    enable = 1'b0; div = 16'd0; clear_underrun = 1'b0; tri_i = 8'h5c;

    // Reset
    step(2);
    aresetn = 1'b1;
    chk("rst_tri_o", 32'(tri_o), 32'h80);
    chk("rst_tri_t", 32'(tri_t), 32'h00);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_tready_low", 32'(tready), 32'd0);
    step(1);
    chk("rst_tready_high", 32'(tready), 32'd1);

    // Pacing: three codes spaced div+1 = 4 cycles
    push(8'd10, 1'b0); push(8'd20, 1'b0); push(8'd30, 1'b0);
    div = 16'd3; enable = 1'b1;
    prev = tri_o; nchg = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tri_o != prev && nchg < 3) begin
        chg_at[nchg] = i;
        nchg++;
      end
      prev = tri_o;
    end
    chk("pace_changes", 32'(nchg), 32'd3);
    chk("pace_first", 32'(chg_at[0]), 32'd5);
    chk("pace_gap1", 32'(chg_at[1] - chg_at[0]), 32'd4);
    chk("pace_gap2", 32'(chg_at[2] - chg_at[1]), 32'd4);
    chk("pace_last_code", 32'(tri_o), 32'd30);
    step(1);

    // Full: 20 offered words, only 16 accepted
    enable = 1'b0; clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tdata = 8'(100 + j); tvalid = 1'b1;
      step(1);
    end
    tvalid = 1'b0;
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_tready", 32'(tready), 32'd0);

    // Drain at div=0: oldest 100 first, newest accepted 115 last, then underrun
    div = 16'd0; enable = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 2) chk("drain_first", 32'(tri_o), 32'd100);
      if (i == 17) chk("drain_last", 32'(tri_o), 32'd115);
      if (i == 18) begin
        chk("drain_hold", 32'(tri_o), 32'd115);
        chk("drain_underrun", 32'(underrun), 32'd1);
      end
    end
    step(1);

    // Underrun with a single word
    enable = 1'b0; clear_underrun = 1'b1; tdata = 8'h5a; tvalid = 1'b1;
    step(1);
    clear_underrun = 1'b0; tvalid = 1'b0;
    step(1);
    chk("clr_underrun", 32'(underrun), 32'd0);
    enable = 1'b1; clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    @(negedge clk);
    chk("ur_tri_o", 32'(tri_o), 32'h5a);
    chk("ur_flag_pre", 32'(underrun), 32'd0);
    step(1);
    @(negedge clk);
    chk("ur_tri_hold", 32'(tri_o), 32'h5a);
    chk("ur_flag_set", 32'(underrun), 32'd1);
    step(1);
    enable = 1'b0; clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;
    @(negedge clk);
    chk("ur_flag_clr", 32'(underrun), 32'd0);
    chk("ur_idle", 32'(tri_o), 32'h80);
    step(1);

    // Disable mid-stream after the first pop
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0);
    div = 16'd2; enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (tri_o == 8'h11) found = 1'b1;
    end
    chk("dis_first_pop_seen", 32'(found), 32'd1);
    step(1);
    enable = 1'b0;
    step(1);
    @(negedge clk);
    chk("dis_idle", 32'(tri_o), 32'h80);
    chk("dis_level", 32'(fifo_level), 32'd2);
    step(1);

    // Lowering div below the running count ticks immediately
    do_reset();
    div = 16'd10; enable = 1'b1;
    step(6);
    div = 16'd2;
    @(negedge clk);
    chk("divlow_pre", 32'(underrun), 32'd0);
    step(1);
    @(negedge clk);
    chk("divlow_tick", 32'(underrun), 32'd1);
    step(1);
    enable = 1'b0; clear_underrun = 1'b1;
    step(1);
    clear_underrun = 1'b0;

    // Concurrent push and pop keep the level constant
    div = 16'd0;
    push(8'h40, 1'b0);
    enable = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tdata = 8'(8'h40 + j); tvalid = 1'b1;
      if (j == 3) begin
        @(negedge clk);
        chk("conc_level", 32'(fifo_level), 32'd1);
        chk("conc_tri_o", 32'(tri_o), 32'h41);
      end
      step(1);
    end
    tvalid = 1'b0;
    step(3);
    enable = 1'b0;
    step(1);

    // Frame marker on the tlast entry
    do_reset();
    push(8'd5, 1'b0); push(8'd6, 1'b1); push(8'd7, 1'b0);
    div = 16'd1; enable = 1'b1;
    pulses = 0; pulse_tri = 8'h00;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (frame_done) begin
        pulses++;
        pulse_tri = tri_o;
      end
    end
`ifdef PMODR2R_PACER_TLAST_EN
    chk("frame_pulses", 32'(pulses), 32'd1);
    chk("frame_tri_o", 32'(pulse_tri), 32'd6);
`else
    chk("frame_pulses", 32'(pulses), 32'd0);
`endif
    step(1);
    enable = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
